// File: rtl/alu_issue_sched.sv
// alu_issue_sched: ALU reservation station with CDB wakeup, dispatch bypass and single-op issue per cycle.
// Define ALU_SCHED_OLDEST_FIRST_EN for age-matrix oldest-first selection; default is lowest-index-first.
module alu_issue_sched #(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_BIT = 3,
  parameter int ROB_W     = 4,
  parameter int TYPE_W    = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              disp_valid,
  input  logic [TYPE_W-1:0] disp_type,
  input  logic [ROB_W-1:0]  disp_rob_id,
  input  logic [31:0]       disp_v1,
  input  logic [31:0]       disp_v2,
  input  logic              disp_dep1,
  input  logic              disp_dep2,
  input  logic [ROB_W-1:0]  disp_q1,
  input  logic [ROB_W-1:0]  disp_q2,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob_id,
  input  logic [31:0]       cdb_val,
  output logic              rs_full,
  output logic              alu_input,
  output logic [TYPE_W-1:0] arith_type,
  output logic [31:0]       r1_val,
  output logic [31:0]       r2_val,
  output logic [ROB_W-1:0]  inst_rob_id
);
  typedef struct packed {
    logic              busy;
    logic [TYPE_W-1:0] typ;
    logic [ROB_W-1:0]  rob;
    logic [31:0]       v1;
    logic [31:0]       v2;
    logic              dep1;
    logic              dep2;
    logic [ROB_W-1:0]  q1;
    logic [ROB_W-1:0]  q2;
  } ent_t;
  ent_t ent_q [ENTRY_NUM];
  ent_t ent_d [ENTRY_NUM];
  logic [ENTRY_BIT:0] cnt_q, cnt_d;
  logic alu_q, alu_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [31:0] r1_q, r1_d, r2_q, r2_d;
  logic [ENTRY_NUM-1:0] busy, rdy;
  logic [ENTRY_BIT-1:0] sel, free;
  logic any_rdy, acc, byp1, byp2;
  assign rs_full = cnt_q == (ENTRY_BIT+1)'(ENTRY_NUM);
  assign acc = disp_valid && !rs_full;
  assign any_rdy = |rdy;
  assign byp1 = cdb_valid && disp_dep1 && disp_q1 == cdb_rob_id;
  assign byp2 = cdb_valid && disp_dep2 && disp_q2 == cdb_rob_id;
  assign alu_input = alu_q;
  assign arith_type = type_q;
  assign r1_val = r1_q;
  assign r2_val = r2_q;
  assign inst_rob_id = rob_q;
  always_comb begin
    busy = '0;
    rdy = '0;
    free = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      busy[i] = ent_q[i].busy;
      rdy[i] = ent_q[i].busy && !ent_q[i].dep1 && !ent_q[i].dep2;
    end
    for (int i = ENTRY_NUM - 1; i >= 0; i--) free = busy[i] ? free : ENTRY_BIT'(i);
  end
`ifdef ALU_SCHED_OLDEST_FIRST_EN
  // age_q[i][j] set means entry j was allocated before entry i
  logic [ENTRY_NUM-1:0] age_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] age_d [ENTRY_NUM];
  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRY_NUM; i++) sel = (rdy[i] && !(|(age_q[i] & rdy))) ? ENTRY_BIT'(i) : sel;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) sel = rdy[i] ? ENTRY_BIT'(i) : sel;
  end
`endif
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    alu_d = 1'b0;
    type_d = type_q;
    rob_d = rob_q;
    r1_d = r1_q;
    r2_d = r2_q;
`ifdef ALU_SCHED_OLDEST_FIRST_EN
    age_d = age_q;
`endif
    if (clear_in) begin
      for (int i = 0; i < ENTRY_NUM; i++) ent_d[i].busy = 1'b0;
      cnt_d = '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (cdb_valid && ent_q[i].busy && ent_q[i].dep1 && ent_q[i].q1 == cdb_rob_id) begin
          ent_d[i].v1 = cdb_val;
          ent_d[i].dep1 = 1'b0;
        end
        if (cdb_valid && ent_q[i].busy && ent_q[i].dep2 && ent_q[i].q2 == cdb_rob_id) begin
          ent_d[i].v2 = cdb_val;
          ent_d[i].dep2 = 1'b0;
        end
      end
      if (any_rdy) begin
        ent_d[sel].busy = 1'b0;
        alu_d = 1'b1;
        type_d = ent_q[sel].typ;
        rob_d = ent_q[sel].rob;
        r1_d = ent_q[sel].v1;
        r2_d = ent_q[sel].v2;
      end
      if (acc) begin
        ent_d[free].busy = 1'b1;
        ent_d[free].typ = disp_type;
        ent_d[free].rob = disp_rob_id;
        ent_d[free].v1 = byp1 ? cdb_val : disp_v1;
        ent_d[free].v2 = byp2 ? cdb_val : disp_v2;
        ent_d[free].dep1 = disp_dep1 && !byp1;
        ent_d[free].dep2 = disp_dep2 && !byp2;
        ent_d[free].q1 = disp_q1;
        ent_d[free].q2 = disp_q2;
`ifdef ALU_SCHED_OLDEST_FIRST_EN
        for (int j = 0; j < ENTRY_NUM; j++) age_d[j][free] = 1'b0;
        age_d[free] = busy;
`endif
      end
      cnt_d = cnt_q + (ENTRY_BIT+1)'(acc) - (ENTRY_BIT+1)'(any_rdy);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRY_NUM; i++) ent_q[i] <= '0;
`ifdef ALU_SCHED_OLDEST_FIRST_EN
      for (int i = 0; i < ENTRY_NUM; i++) age_q[i] <= '0;
`endif
      cnt_q <= '0;
      alu_q <= 1'b0;
      type_q <= '0;
      rob_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
    end else if (rdy_in) begin
      ent_q <= ent_d;
`ifdef ALU_SCHED_OLDEST_FIRST_EN
      age_q <= age_d;
`endif
      cnt_q <= cnt_d;
      alu_q <= alu_d;
      type_q <= type_d;
      rob_q <= rob_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed stimulus with a queue scoreboard checked by an independent issue monitor.
module tb_alu_issue_sched;
  logic clk_in = 0, rst_in = 1, rdy_in = 1, clear_in = 0;
  logic disp_valid = 0, disp_dep1 = 0, disp_dep2 = 0, cdb_valid = 0;
  logic [3:0] disp_type = 0, disp_rob_id = 0, disp_q1 = 0, disp_q2 = 0, cdb_rob_id = 0;
  logic [31:0] disp_v1 = 0, disp_v2 = 0, cdb_val = 0;
  logic rs_full, alu_input;
  logic [3:0] arith_type, inst_rob_id;
  logic [31:0] r1_val, r2_val;
  typedef struct packed {
    logic [3:0] t;
    logic [3:0] rob;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0;
  logic adv = 0;
  always #5 clk_in = ~clk_in;
  alu_issue_sched dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_val(cdb_val), .rs_full(rs_full), .alu_input(alu_input), .arith_type(arith_type),
    .r1_val(r1_val), .r2_val(r2_val), .inst_rob_id(inst_rob_id)
  );
  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // a new issue is only presented after an edge where state was allowed to advance
  always @(posedge clk_in) adv = rdy_in && !rst_in;
  always @(negedge clk_in) begin
    if (adv && alu_input) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL spurious_issue: got rob %0h r1 %0h r2 %0h expected no issue", inst_rob_id, r1_val, r2_val);
      end else chk("issue", {arith_type, inst_rob_id, r1_val, r2_val}, q.pop_front());
    end
  end
  task automatic disp(input logic [3:0] t, input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic d1, input logic [3:0] x1, input logic d2, input logic [3:0] x2);
    disp_valid = 1; disp_type = t; disp_rob_id = r; disp_v1 = a; disp_v2 = b;
    disp_dep1 = d1; disp_q1 = x1; disp_dep2 = d2; disp_q2 = x2;
    @(negedge clk_in);
    disp_valid = 0; disp_dep1 = 0; disp_dep2 = 0;
  endtask
  task automatic cdb(input logic [3:0] r, input logic [31:0] v);
    cdb_valid = 1; cdb_rob_id = r; cdb_val = v;
    @(negedge clk_in);
    cdb_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  initial begin
    idle(2);
    chk("reset_alu_input", 72'(alu_input), 0);
    chk("reset_outputs", {arith_type, inst_rob_id, r1_val, r2_val}, 0);
    chk("reset_rs_full", 72'(rs_full), 0);
    rst_in = 0;
    q.push_back('{4'd0, 4'd3, 32'd5, 32'd7});
    disp(4'd0, 4'd3, 32'd5, 32'd7, 0, 0, 0, 0);
    idle(3);
    chk("occupancy_empty", 72'(rs_full), 0);
    disp(4'd1, 4'd4, 32'd0, 32'd2, 1, 4'd6, 0, 0);
    idle(2);
    q.push_back('{4'd1, 4'd4, 32'h10, 32'd2});
    cdb(4'd6, 32'h10);
    idle(3);
    cdb_valid = 1; cdb_rob_id = 4'd2; cdb_val = 32'd9;
    q.push_back('{4'd2, 4'd5, 32'd1, 32'd9});
    disp(4'd2, 4'd5, 32'd1, 32'd0, 0, 0, 1, 4'd2);
    cdb_valid = 0;
    idle(3);
    for (int i = 0; i < 8; i++) begin
      q.push_back('{4'(i), 4'(i + 8), 32'h100, 32'(i * 3)});
      disp(4'(i), 4'(i + 8), 32'd0, 32'(i * 3), 1, 4'd1, 0, 0);
    end
    chk("rs_full_at_8", 72'(rs_full), 1);
    disp(4'd9, 4'd7, 32'hdead, 32'hbeef, 0, 0, 0, 0);
    chk("rs_full_after_drop", 72'(rs_full), 1);
    cdb(4'd1, 32'h100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      chk("burst_issue", 72'(alu_input), 1);
    end
    @(negedge clk_in);
    chk("burst_end", 72'(alu_input), 0);
    chk("burst_rs_empty", 72'(rs_full), 0);
    for (int i = 0; i < 3; i++) begin
      q.push_back('{4'd3, 4'(i), 32'h12, 32'(i)});
      disp(4'd3, 4'(i), 32'd0, 32'(i), 1, 4'd12, 0, 0);
    end
    disp(4'd4, 4'd9, 32'h44, 32'd0, 0, 0, 1, 4'd13);
    cdb(4'd12, 32'h12);
    idle(5);
`ifdef ALU_SCHED_OLDEST_FIRST_EN
    q.push_back('{4'd4, 4'd9, 32'h44, 32'h13});
    q.push_back('{4'd5, 4'd10, 32'h55, 32'h66});
`else
    q.push_back('{4'd5, 4'd10, 32'h55, 32'h66});
    q.push_back('{4'd4, 4'd9, 32'h44, 32'h13});
`endif
    cdb_valid = 1; cdb_rob_id = 4'd13; cdb_val = 32'h13;
    disp(4'd5, 4'd10, 32'h55, 32'h66, 0, 0, 0, 0);
    cdb_valid = 0;
    idle(4);
    for (int i = 0; i < 4; i++) disp(4'd7, 4'(i), 32'd0, 32'd1, 1, 4'd14, 0, 0);
    cdb(4'd14, 32'h14);
    clear_in = 1;
    @(negedge clk_in);
    clear_in = 0;
    chk("clear_alu_input", 72'(alu_input), 0);
    chk("clear_rs_full", 72'(rs_full), 0);
    idle(5);
    for (int i = 0; i < 3; i++) begin
      q.push_back('{4'd6, 4'(i + 1), 32'h77, 32'(i + 'h31)});
      disp(4'd6, 4'(i + 1), 32'd0, 32'(i + 'h31), 1, 4'd15, 0, 0);
    end
    cdb(4'd15, 32'h77);
    @(negedge clk_in);
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("stall_alu_input", 72'(alu_input), 1);
      chk("stall_outputs", {arith_type, inst_rob_id, r1_val, r2_val}, {4'd6, 4'd1, 32'h77, 32'h31});
    end
    rdy_in = 1;
    idle(6);
    chk("drain", 72'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
